// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART/ALU frame sequencer and the ALU it drives.
package uart_alu_pkg;

    localparam int N    = 8;
    localparam int OP_W = 6;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND,
        WAIT_TX
    } ctrl_state_t;

    // Opcode values the ALU decodes; the sequencer only forwards them.
    localparam logic [OP_W-1:0] ADD = 6'h20;
    localparam logic [OP_W-1:0] SUB = 6'h22;
    localparam logic [OP_W-1:0] AND = 6'h24;
    localparam logic [OP_W-1:0] OR  = 6'h25;
    localparam logic [OP_W-1:0] XOR = 6'h26;
    localparam logic [OP_W-1:0] SRA = 6'h03;
    localparam logic [OP_W-1:0] SRL = 6'h02;
    localparam logic [OP_W-1:0] NOR = 6'h27;

endpackage

// File: rtl/uart_alu_ctrl_if.sv
// Bundle of UART receive, ALU and UART transmit signals seen by the frame sequencer.
interface uart_alu_ctrl_if #(
    parameter int N     = uart_alu_pkg::N,
    parameter int OP_W  = uart_alu_pkg::OP_W,
    parameter int CNT_W = 16
);

    logic [N-1:0]     rx_data;
    logic             rx_valid;
    logic [N-1:0]     alu_a;
    logic [N-1:0]     alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [N-1:0]     alu_result;
    logic [N-1:0]     tx_data;
    logic             tx_start;
    logic             tx_busy;
    logic             tx_done;
    logic             busy;
    logic             overrun;
    logic             timeout_err;
    logic [CNT_W-1:0] frame_cnt;

    // master: the sequencer; slave: receiver, ALU and transmitter around it.
    modport master (
        input  rx_data, rx_valid, alu_result, tx_busy, tx_done,
        output alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout_err, frame_cnt
    );

    modport slave (
        output rx_data, rx_valid, alu_result, tx_busy, tx_done,
        input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout_err, frame_cnt
    );

endinterface

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts cycles while run is high and flags the last allowed cycle.
module frame_timer #(
    parameter int TIMEOUT_CYC = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        // NOTE: default assignment first, so no path through this block can infer a latch.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT_CYC > 0) && run && (count_q == LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: gathers A, B, opcode from the UART, runs the ALU, hands the result to the TX.
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int N           = uart_alu_pkg::N,
    parameter int OP_W        = uart_alu_pkg::OP_W,
    parameter int TIMEOUT_CYC = 5000000,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            reset,
    uart_alu_ctrl_if.master bus
);

    ctrl_state_t      state_q;
    logic [N-1:0]     alu_a_q;
    logic [N-1:0]     alu_b_q;
    logic [OP_W-1:0]  alu_op_q;
    logic [N-1:0]     tx_data_q;
    logic             busy_q;
    logic             overrun_q;
    logic             timeout_err_q;
    logic [CNT_W-1:0] frame_cnt_q;

    logic timer_clear;
    logic timer_run;
    logic timer_expired;
    logic tx_start;

    // The timer restarts on the byte that moves us into WAIT_B or WAIT_OP.
    assign timer_run   = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timer_clear = bus.rx_valid && ((state_q == WAIT_A) || (state_q == WAIT_B));

    // Decoded from tx_busy directly so the request lands in the first idle SEND cycle.
    assign tx_start = (state_q == SEND) && !bus.tx_busy;

    frame_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .run    (timer_run),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_A;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            tx_data_q     <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            timeout_err_q <= 1'b0;
            unique case (state_q)
                WAIT_A: begin
                    if (bus.rx_valid) begin
                        alu_a_q <= bus.rx_data;
                        busy_q  <= 1'b1;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.rx_valid) begin
                        alu_b_q <= bus.rx_data;
                        state_q <= WAIT_OP;
                    end else if (timer_expired) begin
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (bus.rx_valid) begin
                        alu_op_q <= bus.rx_data[OP_W-1:0];
                        state_q  <= EXEC;
                    end else if (timer_expired) begin
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= WAIT_A;
                    end
                end
                EXEC: begin
                    tx_data_q <= bus.alu_result;
                    state_q   <= SEND;
                end
                SEND: begin
                    if (tx_start) begin
                        state_q <= WAIT_TX;
                    end
                end
                WAIT_TX: begin
                    if (bus.tx_done) begin
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        busy_q      <= 1'b0;
                        state_q     <= WAIT_A;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= WAIT_A;
                end
            endcase

            if (bus.rx_valid && (state_q inside {EXEC, SEND, WAIT_TX})) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_start    = tx_start;
    assign bus.busy        = busy_q;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed and randomized frames against a reference ALU and frame-level expectations.
module tb_uart_alu_ctrl;
    import uart_alu_pkg::*;

    localparam int TO       = 20;
    localparam int TB_CNT_W = 3;
    localparam logic [5:0] OPS [8] = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR};

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_cmp   = 0;
    int n_bad   = 0;
    int exp_cnt = 0;
    bit exp_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_alu_ctrl_if #(.N(8), .OP_W(6), .CNT_W(TB_CNT_W)) bus ();

    uart_alu_ctrl #(
        .N          (8),
        .OP_W       (6),
        .TIMEOUT_CYC(TO),
        .CNT_W      (TB_CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            SRA:     return 8'($signed(a) >>> b[2:0]);
            SRL:     return a >> b[2:0];
            NOR:     return ~(a | b);
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        cyc();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic pulse_done();
        bus.tx_done = 1'b1;
        cyc();
        bus.tx_done = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_alu_a"},    32'(bus.alu_a), 0);
        check({tag, "_alu_b"},    32'(bus.alu_b), 0);
        check({tag, "_alu_op"},   32'(bus.alu_op), 0);
        check({tag, "_tx_data"},  32'(bus.tx_data), 0);
        check({tag, "_tx_start"}, 32'(bus.tx_start), 0);
        check({tag, "_busy"},     32'(bus.busy), 0);
        check({tag, "_overrun"},  32'(bus.overrun), 0);
        check({tag, "_tmo"},      32'(bus.timeout_err), 0);
        check({tag, "_cnt"},      32'(bus.frame_cnt), 0);
    endtask

    task automatic wait_start(output int waited);
        waited = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                waited = i;
                break;
            end
            cyc();
        end
    endtask

    // Called at the start of the cycle after the opcode byte was accepted.
    task automatic finish_frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                                input int busy_len, input bit poke, input string tag);
        logic [7:0] exp_tx;
        int waited;
        exp_tx = alu_model(a, b, op);
        @(negedge clk);
        check({tag, "_alu_a"},       32'(bus.alu_a), 32'(a));
        check({tag, "_alu_b"},       32'(bus.alu_b), 32'(b));
        check({tag, "_alu_op"},      32'(bus.alu_op), 32'(op));
        check({tag, "_exec_nostart"}, 32'(bus.tx_start), 0);
        check({tag, "_no_tmo"},      32'(bus.timeout_err), 0);
        cyc();
        for (int i = 0; i < busy_len; i++) begin
            @(negedge clk);
            check({tag, "_busy_nostart"}, 32'(bus.tx_start), 0);
            cyc();
        end
        bus.tx_busy = 1'b0;
        wait_start(waited);
        check({tag, "_start_lat"}, 32'(waited), 0);
        check({tag, "_tx_data"},   32'(bus.tx_data), 32'(exp_tx));
        cyc();
        if (poke) begin
            send(8'h77);
            exp_ovr = 1'b1;
        end
        @(negedge clk);
        check({tag, "_one_pulse"}, 32'(bus.tx_start), 0);
        check({tag, "_busy_tx"},   32'(bus.busy), 1);
        check({tag, "_hold_a"},    32'(bus.alu_a), 32'(a));
        check({tag, "_hold_tx"},   32'(bus.tx_data), 32'(exp_tx));
        check({tag, "_ovr_tx"},    32'(bus.overrun), 32'(exp_ovr));
        pulse_done();
        exp_cnt++;
        @(negedge clk);
        check({tag, "_cnt"},  32'(bus.frame_cnt), 32'(exp_cnt % (1 << TB_CNT_W)));
        check({tag, "_idle"}, 32'(bus.busy), 0);
        check({tag, "_ovr"},  32'(bus.overrun), 32'(exp_ovr));
        cyc();
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                             input logic [1:0] hi, input int busy_len, input bit poke,
                             input string tag);
        bus.tx_busy = (busy_len > 0);
        send(a);
        send(b);
        send({hi, op});
        finish_frame(a, b, op, busy_len, poke, tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [5:0] rop;
        logic [1:0] rhi;
        bit early;

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;
        bus.tx_busy  = 1'b0;
        bus.tx_done  = 1'b0;
        reset        = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check_zero("rst");
        cyc();
        reset = 1'b0;

        // A stray tx_done while idle must not count a frame.
        pulse_done();
        @(negedge clk);
        check("stray_done_cnt", 32'(bus.frame_cnt), 0);
        cyc();

        run_frame(8'h05, 8'h03, ADD, 2'b00, 0, 1'b0, "nominal");
        run_frame(8'h40, 8'h11, SUB, 2'b00, 10, 1'b0, "txbusy");

        // Stalled frame: only operand A arrives.
        bus.tx_busy = 1'b0;
        send(8'hAA);
        early = 1'b0;
        repeat (TO) begin
            @(negedge clk);
            if (bus.timeout_err !== 1'b0) early = 1'b1;
            cyc();
        end
        @(negedge clk);
        check("tmo_not_early", 32'(early), 0);
        check("tmo_pulse",     32'(bus.timeout_err), 1);
        check("tmo_idle",      32'(bus.busy), 0);
        check("tmo_keep_a",    32'(bus.alu_a), 32'h0000_00AA);
        cyc();
        @(negedge clk);
        check("tmo_one_cycle", 32'(bus.timeout_err), 0);
        cyc();
        run_frame(8'h01, 8'h02, SUB, 2'b00, 0, 1'b0, "after_tmo");

        // Second and third bytes each arrive on the expiry cycle.
        send(8'h3C);
        repeat (TO - 1) cyc();
        send(8'h05);
        @(negedge clk);
        check("edge_b_no_tmo", 32'(bus.timeout_err), 0);
        check("edge_b_busy",   32'(bus.busy), 1);
        check("edge_b_alu_b",  32'(bus.alu_b), 32'h0000_0005);
        repeat (TO - 1) cyc();
        send({2'b00, XOR});
        finish_frame(8'h3C, 8'h05, XOR, 0, 1'b0, "edge");

        run_frame(8'h9E, 8'h0F, AND, 2'b00, 0, 1'b1, "overrun");

        for (int f = 0; f < 6; f++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = OPS[$urandom_range(0, 7)];
            rhi = 2'($urandom);
            run_frame(ra, rb, rop, rhi, int'($urandom_range(0, 3)), 1'b0, $sformatf("rand%0d", f));
        end

        // Reset while parked in SEND.
        bus.tx_busy = 1'b1;
        send(8'h21);
        send(8'h12);
        send({2'b00, OR});
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset   = 1'b0;
        exp_cnt = 0;
        exp_ovr = 1'b0;
        @(negedge clk);
        check_zero("rst_send");
        cyc();

        // Reset while waiting for the opcode.
        bus.tx_busy = 1'b0;
        send(8'h66);
        send(8'h07);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        check_zero("rst_wop");
        cyc();

        ra = 8'($urandom);
        rb = 8'($urandom);
        run_frame(ra, rb, NOR, 2'b00, 0, 1'b0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Frame sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes per command, in order: operand A, operand B, opcode.
- Drives the registered operands and opcode to the combinational ALU and captures the result.
- Hands the result to the transmitter using a start/done handshake.
- Recovers from stalled partial frames with a timeout, and flags bytes that arrive while a command is in flight.

Parameters:
- N, 8, data/operand width in bits; must equal the UART data width.
- OP_W, 6, opcode width; taken from rx_data[OP_W-1:0], upper bits ignored.
- TIMEOUT_CYC, 5000000, clk cycles allowed between bytes of one frame; 0 disables the timeout.
- CNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  N  received byte, valid only while rx_valid=1
- rx_valid  in  1  one-cycle pulse per received byte, clk domain
- alu_a  out  N  operand A, registered
- alu_b  out  N  operand B, registered
- alu_op  out  OP_W  opcode, registered
- alu_result  in  N  combinational ALU result
- tx_data  out  N  byte to transmit, registered
- tx_start  out  1  one-cycle pulse requesting transmission
- tx_busy  in  1  transmitter occupied
- tx_done  in  1  one-cycle pulse when the stop bit has finished
- busy  out  1  high in every state except WAIT_A
- overrun  out  1  sticky; a byte was dropped
- timeout_err  out  1  one-cycle pulse when a partial frame is aborted
- frame_cnt  out  CNT_W  completed commands; wraps modulo 2^CNT_W

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset takes priority over every other input, including mid-frame and mid-transmission.
  - State goes to WAIT_A; the timer clears.
  - alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun, timeout_err and frame_cnt all go to 0.
- State machine (registered state, enumerated type):
  - WAIT_A: on rx_valid, alu_a<=rx_data; go to WAIT_B.
  - WAIT_B: on rx_valid, alu_b<=rx_data; go to WAIT_OP.
  - WAIT_OP: on rx_valid, alu_op<=rx_data[OP_W-1:0]; go to EXEC.
  - EXEC: exactly one cycle so the ALU inputs settle; tx_data<=alu_result; go to SEND.
  - SEND: if tx_busy=0, assert tx_start for this one cycle and go to WAIT_TX; otherwise stay with tx_start=0.
  - WAIT_TX: on tx_done, frame_cnt<=frame_cnt+1 and go to WAIT_A.
- Latency: from the opcode rx_valid cycle, EXEC follows in 1 cycle. tx_start is asserted 2 cycles after the opcode byte when tx_busy=0.
- alu_a, alu_b and alu_op hold their values until the next frame overwrites them. A partial frame leaves the captured registers modified; nothing is restored.
- Timeout (TIMEOUT_CYC>0):
  - The timer clears on entry to WAIT_B and on entry to WAIT_OP.
  - It increments every cycle spent in WAIT_B or WAIT_OP.
  - When it reaches TIMEOUT_CYC-1 with rx_valid=0: go to WAIT_A and pulse timeout_err for 1 cycle.
  - If rx_valid=1 in the same cycle the timer expires, the byte is accepted and there is no timeout.
  - The timer is never active in WAIT_A, EXEC, SEND or WAIT_TX.
- Overrun:
  - rx_valid in EXEC, SEND or WAIT_TX sets overrun=1 and the byte is discarded; the state is unaffected.
  - overrun clears only on reset.
- A tx_done outside WAIT_TX is ignored.
- A tx_done in the same cycle as tx_start is not possible by transmitter contract and does not need handling.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Package uart_alu_pkg contains:
  - the ctrl_state_t enum (WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX);
  - the default widths N=8 and OP_W=6;
  - the opcode localparams shared with the ALU (ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, XOR=6'h26, SRA=6'h03, SRL=6'h02, NOR=6'h27).
- One sub-module, frame_timer, is natural:
  - inputs: clk, reset, clear, run;
  - output: expired;
  - counter width $clog2(TIMEOUT_CYC+1);
  - expired is held at 0 when TIMEOUT_CYC=0.

Test Plan:
- Nominal frame: rx bytes 0x05, 0x03, 0x20 with the ALU model A+B, tx_busy=0.
  - Expect alu_a=0x05, alu_b=0x03, alu_op=0x20.
  - Expect tx_data=0x08 and a single-cycle tx_start 2 cycles after the opcode.
  - After tx_done, expect frame_cnt=1 and busy=0.
- Transmitter busy: tx_busy=1 for 10 cycles after EXEC.
  - Expect no tx_start for those 10 cycles.
  - Expect tx_start on the first cycle with tx_busy=0.
- Timeout: TIMEOUT_CYC=20; send 0xAA, then nothing.
  - Expect a timeout_err pulse 20 cycles after entering WAIT_B, then the state returns to WAIT_A.
  - Expect alu_a=0xAA retained.
  - The next bytes 0x01, 0x02, 0x22 complete normally.
- Boundary: with TIMEOUT_CYC=20, send the second byte exactly on the expiry cycle.
  - Expect no timeout_err and alu_b captured.
- Overrun: send a 4th byte 0x77 during WAIT_TX.
  - Expect overrun=1 held.
  - Expect tx_data and alu_a unchanged and frame_cnt to increment normally on tx_done.
- Reset mid-operation: assert reset in SEND and again in WAIT_OP.
  - Next cycle: all outputs 0 and busy=0.
  - A fresh 3-byte frame then produces a correct result.
